// File: rtl/axi_stream_checker.sv
// ---------------------------------------------------------------------------
// axi_stream_checker
//
// AXI4-Stream slave that consumes one packet per arm command and checks it
// against the stream generator's contract: incrementing data starting at 0,
// the programmed beat count with TLAST only on the final beat, the programmed
// TDEST, and the AXI-Stream rule that a stalled beat must be held stable.
// TREADY follows a programmable 8-phase backpressure pattern.
//
// Ports:
//   clock, reset           - single rising-edge clock, async active-high reset
//   TDATA/TLAST/TID/TDEST  - stream payload from the master (TID is ignored)
//   TVALID / TREADY        - stream handshake (TREADY is registered)
//   arm                    - one-cycle pulse, starts checking of one packet
//   expected_beats         - beats expected in the packet (latched on arm)
//   expected_dest          - expected TDEST (latched on arm)
//   stall_mask             - bit i enables TREADY in phase i (latched on arm)
//   busy / done            - checker is receiving / has finished a packet
//   pass                   - overall verdict, meaningful while done=1
//   beat_count             - beats accepted in the current packet
//   data_errors            - beats whose data mismatched (saturating)
//   length_error           - TLAST missing, early or late (sticky per packet)
//   dest_error             - TDEST mismatch seen (sticky per packet)
//   protocol_error         - stalled beat was dropped or changed (sticky)
//   packet_count           - packets completed since reset (wraps)
// ---------------------------------------------------------------------------
module axi_stream_checker #(
    parameter int STREAM_DATA_WIDTH = 32,
    parameter int STREAM_ID_WIDTH   = 2,
    parameter int ERR_CNT_WIDTH     = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [STREAM_DATA_WIDTH-1:0] TDATA,
    input  logic                         TLAST,
    input  logic [STREAM_ID_WIDTH-1:0]   TID,
    input  logic [1:0]                   TDEST,
    input  logic                         TVALID,
    output logic                         TREADY,
    input  logic                         arm,
    input  logic [23:0]                  expected_beats,
    input  logic [1:0]                   expected_dest,
    input  logic [7:0]                   stall_mask,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [23:0]                  beat_count,
    output logic [ERR_CNT_WIDTH-1:0]     data_errors,
    output logic                         length_error,
    output logic                         dest_error,
    output logic                         protocol_error,
    output logic [15:0]                  packet_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                       state_q, state_d;

    // Configuration captured on arm
    logic [23:0]                  beats_cfg_q, beats_cfg_d;
    logic [1:0]                   dest_cfg_q, dest_cfg_d;
    logic [7:0]                   mask_cfg_q, mask_cfg_d;

    // Backpressure phase and registered ready
    logic [2:0]                   phase_q, phase_d;
    logic                         tready_q, tready_d;

    // Per-packet status
    logic [23:0]                  beat_count_q, beat_count_d;
    logic [ERR_CNT_WIDTH-1:0]     data_errors_q, data_errors_d;
    logic                         length_error_q, length_error_d;
    logic                         dest_error_q, dest_error_d;
    logic                         protocol_error_q, protocol_error_d;
    logic                         pass_q, pass_d;
    logic [15:0]                  packet_count_q, packet_count_d;

    // Snapshot of the previous cycle's stream inputs for the hold check
    logic                         stall_prev_q, stall_prev_d;
    logic [STREAM_DATA_WIDTH-1:0] data_prev_q, data_prev_d;
    logic                         last_prev_q, last_prev_d;
    logic [1:0]                   dest_prev_q, dest_prev_d;

    logic                         accept;
    logic                         hold_violation;
    logic                         at_final_beat;
    logic [23:0]                  final_index;
    logic [STREAM_DATA_WIDTH-1:0] expected_data;

    // TID carries no meaning for this checker
    logic                         unused_tid;
    assign unused_tid = ^TID;

    // tready_q is only ever set while receiving, so it alone qualifies a beat.
    assign accept        = TVALID & tready_q;
    assign final_index   = beats_cfg_q - 24'd1;
    assign at_final_beat = (beat_count_q == final_index);
    // Beat index zero-extended or truncated to the data width.
    assign expected_data = STREAM_DATA_WIDTH'(beat_count_q);

    // A beat offered without ready last cycle must still be offered, unchanged.
    assign hold_violation = stall_prev_q &
                            (!TVALID ||
                             (TDATA != data_prev_q) ||
                             (TLAST != last_prev_q) ||
                             (TDEST != dest_prev_q));

    // Next-state, configuration capture and per-beat checking
    always_comb begin
        state_d          = state_q;
        beats_cfg_d      = beats_cfg_q;
        dest_cfg_d       = dest_cfg_q;
        mask_cfg_d       = mask_cfg_q;
        phase_d          = phase_q;
        beat_count_d     = beat_count_q;
        data_errors_d    = data_errors_q;
        length_error_d   = length_error_q;
        dest_error_d     = dest_error_q;
        protocol_error_d = protocol_error_q;
        pass_d           = pass_q;
        packet_count_d   = packet_count_q;

        stall_prev_d     = TVALID & !tready_q;
        data_prev_d      = TDATA;
        last_prev_d      = TLAST;
        dest_prev_d      = TDEST;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    beats_cfg_d      = expected_beats;
                    dest_cfg_d       = expected_dest;
                    mask_cfg_d       = stall_mask;
                    phase_d          = 3'd0;
                    beat_count_d     = 24'd0;
                    data_errors_d    = '0;
                    length_error_d   = 1'b0;
                    dest_error_d     = 1'b0;
                    protocol_error_d = 1'b0;
                    pass_d           = 1'b0;
                    // An empty packet can never be satisfied: finish at once.
                    if (expected_beats == 24'd0) begin
                        state_d        = ST_DONE;
                        length_error_d = 1'b1;
                        packet_count_d = packet_count_q + 16'd1;
                    end else begin
                        state_d = ST_RECEIVE;
                    end
                end
            end

            ST_RECEIVE: begin
                phase_d = phase_q + 3'd1;

                if (hold_violation) begin
                    protocol_error_d = 1'b1;
                end

                if (accept) begin
                    if (TDATA != expected_data &&
                        data_errors_q != {ERR_CNT_WIDTH{1'b1}}) begin
                        data_errors_d = data_errors_q + ERR_CNT_WIDTH'(1);
                    end
                    if (TDEST != dest_cfg_q) begin
                        dest_error_d = 1'b1;
                    end
                    // TLAST must appear exactly on the final beat: a missing
                    // TLAST there and a TLAST anywhere else are both errors.
                    if (at_final_beat != TLAST) begin
                        length_error_d = 1'b1;
                    end
                    if (beat_count_q != 24'hFF_FFFF) begin
                        beat_count_d = beat_count_q + 24'd1;
                    end
                    // The verdict folds in whatever the final beat itself set.
                    if (TLAST) begin
                        state_d        = ST_DONE;
                        packet_count_d = packet_count_q + 16'd1;
                        pass_d         = (data_errors_d == '0) &&
                                         !length_error_d &&
                                         !dest_error_d &&
                                         !protocol_error_d;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready is registered, so it is derived from where we will be next.
        tready_d = (state_d == ST_RECEIVE) && mask_cfg_d[phase_d];
    end

    // State and status registers, all cleared immediately on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            beats_cfg_q      <= 24'd0;
            dest_cfg_q       <= 2'd0;
            mask_cfg_q       <= 8'd0;
            phase_q          <= 3'd0;
            tready_q         <= 1'b0;
            beat_count_q     <= 24'd0;
            data_errors_q    <= '0;
            length_error_q   <= 1'b0;
            dest_error_q     <= 1'b0;
            protocol_error_q <= 1'b0;
            pass_q           <= 1'b0;
            packet_count_q   <= 16'd0;
            stall_prev_q     <= 1'b0;
            data_prev_q      <= '0;
            last_prev_q      <= 1'b0;
            dest_prev_q      <= 2'd0;
        end else begin
            state_q          <= state_d;
            beats_cfg_q      <= beats_cfg_d;
            dest_cfg_q       <= dest_cfg_d;
            mask_cfg_q       <= mask_cfg_d;
            phase_q          <= phase_d;
            tready_q         <= tready_d;
            beat_count_q     <= beat_count_d;
            data_errors_q    <= data_errors_d;
            length_error_q   <= length_error_d;
            dest_error_q     <= dest_error_d;
            protocol_error_q <= protocol_error_d;
            pass_q           <= pass_d;
            packet_count_q   <= packet_count_d;
            stall_prev_q     <= stall_prev_d;
            data_prev_q      <= data_prev_d;
            last_prev_q      <= last_prev_d;
            dest_prev_q      <= dest_prev_d;
        end
    end

    assign TREADY         = tready_q;
    assign busy           = (state_q == ST_RECEIVE);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign beat_count     = beat_count_q;
    assign data_errors    = data_errors_q;
    assign length_error   = length_error_q;
    assign dest_error     = dest_error_q;
    assign protocol_error = protocol_error_q;
    assign packet_count   = packet_count_q;

endmodule

// File: tb/tb_axi_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_checker
//
// Drives packets into axi_stream_checker acting as a stream master that obeys
// (or deliberately breaks) the hold rule, and compares TREADY and the final
// packet status against a reference computed from the accepted beat list.
// ---------------------------------------------------------------------------
module tb_axi_stream_checker;

   logic        clock;
   logic        reset;
   logic [31:0] TDATA;
   logic        TLAST;
   logic [1:0]  TID;
   logic [1:0]  TDEST;
   logic        TVALID;
   logic        TREADY;
   logic        arm;
   logic [23:0] expected_beats;
   logic [1:0]  expected_dest;
   logic [7:0]  stall_mask;
   logic        busy;
   logic        done;
   logic        pass;
   logic [23:0] beat_count;
   logic [15:0] data_errors;
   logic        length_error;
   logic        dest_error;
   logic        protocol_error;
   logic [15:0] packet_count;

   int compareCount = 0;
   int mismatchCount = 0;
   int packetModel = 0;

   // Packet the master will offer, beat by beat
   logic [31:0] beatData[$];
   logic        beatLast[$];
   logic [1:0]  beatDest[$];

   axi_stream_checker #(
      .STREAM_DATA_WIDTH(32),
      .STREAM_ID_WIDTH(2),
      .ERR_CNT_WIDTH(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .TDATA(TDATA),
      .TLAST(TLAST),
      .TID(TID),
      .TDEST(TDEST),
      .TVALID(TVALID),
      .TREADY(TREADY),
      .arm(arm),
      .expected_beats(expected_beats),
      .expected_dest(expected_dest),
      .stall_mask(stall_mask),
      .busy(busy),
      .done(done),
      .pass(pass),
      .beat_count(beat_count),
      .data_errors(data_errors),
      .length_error(length_error),
      .dest_error(dest_error),
      .protocol_error(protocol_error),
      .packet_count(packet_count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, want finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   // Build an incrementing packet of n beats with TLAST at lastIdx
   task automatic buildPacket(input int n, input int lastIdx, input logic [1:0] dest);
      beatData.delete();
      beatLast.delete();
      beatDest.delete();
      for (int i = 0; i < n; i++) begin
         beatData.push_back(32'(i));
         beatLast.push_back(i == lastIdx);
         beatDest.push_back(dest);
      end
   endtask

   // Arm the checker, play the queued packet and check the outcome.
   // resetAfter >= 0 resets mid-packet once that many beats were accepted;
   // rearmAt >= 0 pulses arm (with different config) in that receive cycle.
   task automatic applyStimulus(input logic [23:0] expBeats, input logic [1:0] expDest,
                                input logic [7:0] mask, input bit holdGlitch,
                                input bit randomGaps, input int resetAfter, input int rearmAt);
      logic [31:0] accData[$];
      logic [1:0]  accDest[$];
      int          idx;
      int          k;
      int          lastPos;
      int          expDataErr;
      bit          finished;
      bit          prevStalled;
      bit          glitchDone;
      bit          protoExp;
      bit          rearmPending;
      bit          curValid;
      bit          rdy;
      bit          expDestErr;
      bit          expLenErr;
      bit          expPass;
      logic [31:0] curData;
      logic [31:0] prevData;
      logic        curLast;
      logic        prevLast;
      logic [1:0]  curDest;
      logic [1:0]  prevDest;

      idx = 0;
      k = 0;
      lastPos = -1;
      finished = 0;
      prevStalled = 0;
      glitchDone = 0;
      protoExp = 0;
      prevData = '0;
      prevLast = 1'b0;
      prevDest = 2'd0;

      @(posedge clock);
      #1;
      arm = 1'b1;
      expected_beats = expBeats;
      expected_dest = expDest;
      stall_mask = mask;
      TVALID = 1'b0;
      @(posedge clock);
      #1;
      arm = 1'b0;
      // Scramble the config inputs: the checker must use its latched copy
      expected_beats = 24'($urandom);
      expected_dest = 2'($urandom);
      stall_mask = 8'($urandom);

      if (expBeats == 24'd0) begin
         packetModel++;
         checkOutput("empty_done", {done, busy, TREADY}, 3'b100);
         checkOutput("empty_status", {pass, length_error, dest_error, protocol_error}, 4'b0100);
         checkOutput("empty_beats", beat_count, 0);
         checkOutput("empty_pkts", packet_count, 16'(packetModel));
         return;
      end

      checkOutput("busy_after_arm", {busy, done}, 2'b10);

      while (!finished && k < 2000) begin
         if (resetAfter >= 0 && accData.size() == resetAfter) begin
            checkOutput("busy_pre_reset", busy, 1);
            #2;
            reset = 1'b1;
            TVALID = 1'b0;
            #1;
            checkOutput("rst_flags", {TREADY, busy, done, pass, length_error, dest_error, protocol_error}, 7'b0);
            checkOutput("rst_counts", {beat_count, data_errors, packet_count}, 0);
            #2;
            reset = 1'b0;
            packetModel = 0;
            return;
         end

         rdy = TREADY;
         checkOutput("tready", rdy, mask[k % 8]);

         curValid = 1'b0;
         if (idx < beatData.size()) begin
            curValid = prevStalled ? 1'b1 : (randomGaps ? ($urandom_range(3) != 0) : 1'b1);
         end
         if (curValid) begin
            curData = beatData[idx];
            curLast = beatLast[idx];
            curDest = beatDest[idx];
            if (prevStalled && holdGlitch && !glitchDone) begin
               curData = curData ^ 32'h1;
               glitchDone = 1;
            end
         end else begin
            curData = $urandom;
            curLast = 1'($urandom);
            curDest = 2'($urandom);
         end
         TVALID = curValid;
         TDATA = curData;
         TLAST = curLast;
         TDEST = curDest;
         TID = 2'($urandom);

         // A stalled beat must still be offered unchanged this cycle
         if (prevStalled && (!curValid || curData != prevData || curLast != prevLast || curDest != prevDest))
            protoExp = 1;

         if (curValid && rdy) begin
            accData.push_back(curData);
            accDest.push_back(curDest);
            idx++;
            if (curLast) begin
               finished = 1;
               lastPos = accData.size() - 1;
            end
         end
         prevStalled = curValid && !rdy;
         prevData = curData;
         prevLast = curLast;
         prevDest = curDest;

         rearmPending = (k == rearmAt);
         if (rearmPending) begin
            arm = 1'b1;
            expected_beats = 24'd3;
            expected_dest = ~expDest;
            stall_mask = 8'hFF;
         end

         @(posedge clock);
         #1;
         if (rearmPending) begin
            arm = 1'b0;
            checkOutput("rearm_ignored", beat_count, 24'(accData.size()));
         end
         k++;
      end

      TVALID = 1'b0;
      checkOutput("timeout", finished, 1);

      // Reference verdict computed directly from the accepted beats
      expDataErr = 0;
      expDestErr = 0;
      foreach (accData[i]) begin
         if (accData[i] != 32'(i)) expDataErr++;
         if (accDest[i] != expDest) expDestErr = 1;
      end
      expLenErr = (lastPos != int'(expBeats) - 1);
      expPass = (expDataErr == 0) && !expLenErr && !expDestErr && !protoExp;
      packetModel++;

      checkOutput("done_state", {done, busy, TREADY}, 3'b100);
      checkOutput("pass", pass, expPass);
      checkOutput("beat_count", beat_count, 24'(accData.size()));
      checkOutput("data_errors", data_errors, 16'(expDataErr));
      checkOutput("length_error", length_error, expLenErr);
      checkOutput("dest_error", dest_error, expDestErr);
      checkOutput("protocol_error", protocol_error, protoExp);
      checkOutput("packet_count", packet_count, 16'(packetModel));

      @(posedge clock);
      #1;
      checkOutput("done_hold", {done, pass, TREADY}, {1'b1, expPass, 1'b0});
   endtask

   initial begin
      int n;
      int variant;
      logic [1:0] dst;

      reset = 1'b1;
      arm = 1'b0;
      TVALID = 1'b0;
      TDATA = '0;
      TLAST = 1'b0;
      TID = '0;
      TDEST = '0;
      expected_beats = '0;
      expected_dest = '0;
      stall_mask = '0;

      #12;
      checkOutput("reset_flags", {TREADY, busy, done, pass, length_error, dest_error, protocol_error}, 7'b0);
      checkOutput("reset_counts", {beat_count, data_errors, packet_count}, 0);
      #1;
      reset = 1'b0;

      $display("[TB] no stall");
      buildPacket(4, 3, 2'd2);
      applyStimulus(24'd4, 2'd2, 8'hFF, 0, 0, -1, -1);

      $display("[TB] backpressure");
      buildPacket(16, 15, 2'd1);
      applyStimulus(24'd16, 2'd1, 8'b0101_0101, 0, 0, -1, -1);

      $display("[TB] corruption");
      buildPacket(8, 7, 2'd1);
      beatData[3] = 32'hDEAD_BEEF;
      beatData[5] = 32'hDEAD_BEEF;
      beatDest[6] = 2'd3;
      applyStimulus(24'd8, 2'd1, 8'hFF, 0, 0, -1, -1);

      $display("[TB] early TLAST");
      buildPacket(3, 2, 2'd0);
      applyStimulus(24'd4, 2'd0, 8'hFF, 0, 0, -1, -1);

      $display("[TB] late TLAST");
      buildPacket(6, 5, 2'd0);
      applyStimulus(24'd4, 2'd0, 8'hFF, 0, 0, -1, -1);

      $display("[TB] zero-beat packet");
      applyStimulus(24'd0, 2'd0, 8'hFF, 0, 0, -1, -1);

      $display("[TB] hold rule violation");
      buildPacket(8, 7, 2'd1);
      applyStimulus(24'd8, 2'd1, 8'b0101_0101, 1, 0, -1, -1);

      $display("[TB] reset mid-packet");
      buildPacket(8, 7, 2'd2);
      applyStimulus(24'd8, 2'd2, 8'hFF, 0, 0, 3, -1);

      $display("[TB] re-arm ignored while receiving");
      buildPacket(6, 5, 2'd3);
      applyStimulus(24'd6, 2'd3, 8'hFF, 0, 0, -1, 3);

      $display("[TB] randomized packets");
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(20, 1);
         dst = 2'($urandom);
         variant = $urandom_range(3, 0);
         buildPacket(n, n - 1, dst);
         if (variant == 2) beatData[$urandom_range(n - 1, 0)] = $urandom;
         if (variant == 3) beatDest[$urandom_range(n - 1, 0)] = dst ^ 2'd1;
         applyStimulus((variant == 1) ? 24'(n + 1) : 24'(n), dst, 8'($urandom_range(255, 1)),
                       ($urandom_range(3, 0) == 0), 1, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
